// File: rtl/fastserial_echo_fifo.sv
// fastserial_echo_fifo: buffered rx->tx loopback FIFO with a write/busy TX handshake.
// Ports: i_clk/i_rst (sync, active-high), i_rx_data/i_rx_ready from the receiver,
//   o_tx_data/o_tx_write/i_tx_busy to the transmitter, i_clr_ovf, status outputs
//   o_level/o_empty/o_full/o_overflow/o_last_rx, and statistics o_rx_count/o_drop_count
//   which are live only when FASTSERIAL_ECHO_STATS_EN is defined.
module fastserial_echo_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_ready,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_write,
  input  logic              i_tx_busy,
  input  logic              i_clr_ovf,
  output logic [ADDR_W:0]   o_level,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow,
  output logic [DATA_W-1:0] o_last_rx,
  output logic [CNT_W-1:0]  o_rx_count,
  output logic [CNT_W-1:0]  o_drop_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_nx;
  logic              rdy_q;
  logic              rx_edge, pop, push, drop, load_tx;

  assign rx_edge = i_rx_ready & ~rdy_q;
  assign pop     = (state == REQ) & i_tx_busy;
  // full is judged after this edge's pop, so a push alongside a pop always fits
  assign push    = rx_edge & (~o_full | pop);
  assign drop    = rx_edge & o_full & ~pop;

  always_comb begin
    level_nx = o_level;
    if (push & ~pop)
      level_nx = o_level + 1'b1;
    else if (pop & ~push)
      level_nx = o_level - 1'b1;
  end

  always_comb begin
    state_nx = state;
    load_tx  = 1'b0;
    unique case (state)
      IDLE: begin
        // requiring busy low lets an in-flight byte finish after a reset
        if (!o_empty && !i_tx_busy) begin
          state_nx = REQ;
          load_tx  = 1'b1;
        end
      end
      REQ: begin
        if (i_tx_busy)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (!i_tx_busy)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_empty    <= 1'b1;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
      o_tx_write <= 1'b0;
      o_tx_data  <= '0;
      o_last_rx  <= '0;
    end else begin
      state   <= state_nx;
      rdy_q   <= i_rx_ready;
      o_level <= level_nx;
      o_empty <= (level_nx == '0);
      o_full  <= (level_nx == LVL_FULL);
      if (load_tx) begin
        o_tx_data  <= mem[rd_ptr];
        o_tx_write <= 1'b1;
      end else if (pop) begin
        o_tx_write <= 1'b0;
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (rx_edge)
        o_last_rx <= i_rx_data;
      if (drop)
        o_overflow <= 1'b1;
      else if (i_clr_ovf)
        o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= i_rx_data;
  end

`ifdef FASTSERIAL_ECHO_STATS_EN
  logic [CNT_W-1:0] rx_cnt, drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (rx_edge)
        rx_cnt <= rx_cnt + 1'b1;
      if (drop)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign o_rx_count   = rx_cnt;
  assign o_drop_count = drop_cnt;
`else
  assign o_rx_count   = '0;
  assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_fastserial_echo_fifo.sv
// tb_fastserial_echo_fifo: vector table, directed corner sequences and random
// traffic checked against a queue-based model of the echo FIFO.
module tb_fastserial_echo_fifo;

  localparam int DEPTH = 16;
`ifdef FASTSERIAL_ECHO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rx_ready, tx_busy, clr_ovf;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic [4:0]  level;
  logic        empty, full, overflow;
  logic [7:0]  last_rx;
  logic [15:0] rx_count, drop_count;

  always #5 clk = ~clk;

  fastserial_echo_fifo #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_ready  (rx_ready),
    .o_tx_data   (tx_data),
    .o_tx_write  (tx_write),
    .i_tx_busy   (tx_busy),
    .i_clr_ovf   (clr_ovf),
    .o_level     (level),
    .o_empty     (empty),
    .o_full      (full),
    .o_overflow  (overflow),
    .o_last_rx   (last_rx),
    .o_rx_count  (rx_count),
    .o_drop_count(drop_count)
  );

  int errors = 0;
  int checks = 0;

  byte unsigned q[$];
  logic        m_prev;
  logic        m_ovf;
  logic [7:0]  m_last;
  logic [15:0] m_rxc, m_dropc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("last_rx", 32'(last_rx), 32'(m_last));
    chk("rx_count", 32'(rx_count), STATS ? 32'(m_rxc) : 32'd0);
    chk("drop_count", 32'(drop_count), STATS ? 32'(m_dropc) : 32'd0);
    if (tx_write === 1'b1) begin
      chk("tx_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0)
        chk("tx_data", 32'(tx_data), 32'(q[0]));
    end
  endtask

  // One clock: advance the queue model by the rules, then compare #1 after the edge.
  task automatic step();
    bit pop, rxe, drop, was_rst;
    pop     = !rst && (tx_write === 1'b1) && tx_busy;
    rxe     = rx_ready && !m_prev;
    was_rst = rst;
    @(posedge clk);
    if (was_rst) begin
      q.delete();
      m_prev  = 1'b0;
      m_ovf   = 1'b0;
      m_last  = 8'h00;
      m_rxc   = 16'd0;
      m_dropc = 16'd0;
    end else begin
      m_prev = rx_ready;
      drop   = 1'b0;
      if (pop && q.size() > 0)
        void'(q.pop_front());
      if (rxe) begin
        m_last = rx_data;
        m_rxc  = m_rxc + 16'd1;
        if (q.size() < DEPTH) begin
          q.push_back(rx_data);
        end else begin
          drop    = 1'b1;
          m_ovf   = 1'b1;
          m_dropc = m_dropc + 16'd1;
        end
      end
      if (clr_ovf && !drop)
        m_ovf = 1'b0;
    end
    #1;
    check_model();
    if (was_rst)
      chk("rst_write", 32'(tx_write), 32'd0);
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_data  = d;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    step();
  endtask

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [7:0] data;
    logic       busy;
    logic       clr;
    logic [4:0] lvl;
    logic       wr;
    logic [7:0] txd;
    logic       ovf;
  } vec_t;

  vec_t tbl[6];
  byte unsigned got[$];
  byte unsigned exp_b;
  int hold;
  int pb;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 8'h41, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0};

    rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
    tx_busy = 1'b0; clr_ovf = 1'b0;
    m_prev = 1'b0; m_ovf = 1'b0; m_last = 8'h00;
    m_rxc = 16'd0; m_dropc = 16'd0;

    // single-byte echo with exact latency
    for (int i = 0; i < 6; i++) begin
      rst = tbl[i].rst; rx_ready = tbl[i].rdy; rx_data = tbl[i].data;
      tx_busy = tbl[i].busy; clr_ovf = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_write", i), 32'(tx_write), 32'(tbl[i].wr));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      if (tbl[i].wr)
        chk($sformatf("vec%0d_txd", i), 32'(tx_data), 32'(tbl[i].txd));
    end

    // burst to full, then overflow and clear
    rst = 1'b1; step(); rst = 1'b0;
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++)
      push_byte(8'(i));
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_level", 32'(level), 32'd16);
    chk("burst_no_write", 32'(tx_write), 32'd0);
    push_byte(8'hEE);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_drops", 32'(drop_count), STATS ? 32'd1 : 32'd0);
    chk("ovf_rxcnt", 32'(rx_count), STATS ? 32'd17 : 32'd0);
    chk("ovf_last", 32'(last_rx), 32'hEE);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // push on the same edge as a pop while full
    tx_busy = 1'b0; step();
    chk("full_req_write", 32'(tx_write), 32'd1);
    chk("full_req_data", 32'(tx_data), 32'h00);
    got.delete();
    got.push_back(tx_data);
    tx_busy = 1'b1; rx_ready = 1'b1; rx_data = 8'hA5;
    step();
    rx_ready = 1'b0;
    chk("pushpop_level", 32'(level), 32'd16);
    chk("pushpop_write", 32'(tx_write), 32'd0);
    chk("pushpop_ovf", 32'(overflow), 32'd0);

    // act as the transmitter and collect every emitted byte
    hold = 0;
    for (int c = 0; c < 400 && got.size() < 17; c++) begin
      if (tx_busy) begin
        if (hold == 0) tx_busy = 1'b0;
        else hold--;
      end else if (tx_write) begin
        got.push_back(tx_data);
        tx_busy = 1'b1;
        hold = 1;
      end
      step();
    end
    chk("drain_count", 32'(got.size()), 32'd17);
    for (int i = 0; i < 17 && i < got.size(); i++) begin
      exp_b = (i < 16) ? 8'(i) : 8'hA5;
      chk($sformatf("order%0d", i), 32'(got[i]), 32'(exp_b));
    end
    for (int c = 0; c < 4; c++) begin
      tx_busy = 1'b0; step();
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // held ready pushes once
    tx_busy = 1'b1; rx_data = 8'h5A; rx_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    rx_ready = 1'b0; step();
    chk("held_level", 32'(level), 32'd1);

    // reset in the middle of a request
    tx_busy = 1'b0; step();
    chk("midreq_write", 32'(tx_write), 32'd1);
    rst = 1'b1; tx_busy = 1'b1; step(); rst = 1'b0;
    chk("midreq_rst_write", 32'(tx_write), 32'd0);
    chk("midreq_rst_level", 32'(level), 32'd0);
    for (int c = 0; c < 6; c++) begin
      tx_busy = (c < 3);
      step();
      chk("post_rst_quiet", 32'(tx_write), 32'd0);
    end

    // random traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0)
        pb = (c / 500) % 3 == 0 ? 20 : ((c / 500) % 3 == 1 ? 55 : 90);
      if ($urandom_range(0, 2) == 0) rx_ready = ~rx_ready;
      rx_data = 8'($urandom);
      tx_busy = ($urandom_range(0, 99) < pb);
      clr_ovf = ($urandom_range(0, 31) == 0);
      rst     = ($urandom_range(0, 699) == 0);
      step();
    end
    rst = 1'b0; clr_ovf = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fastserial_echo_fifo.md
# fastserial_echo_fifo

Parametrised buffered loopback stage between the fast-serial receiver (`rx_fastserial`) and transmitter (`tx_fastserial`), clocked in the 100 MHz fast-serial domain. It replaces the single-register echo path with a FIFO, so bursts from the FTDI host are not lost while the transmitter waits on CTS. It drives the transmitter with a write/busy handshake, reports the FIFO state, keeps a sticky overflow flag, and can optionally keep byte statistics.

## Interface

Parameters:

- DATA_W, 8, byte width carried through FIFO and TX interface
- ADDR_W, 4, FIFO address width; depth = 2^ADDR_W entries
- CNT_W, 16, statistics counter width

Ports:

- i_clk  in  1  fast-serial system clock (100 MHz PLL output)
- i_rst  in  1  reset; **one clock; reset is synchronous and active-high**
- i_rx_data  in  DATA_W  byte from receiver
- i_rx_ready  in  1  receiver byte-valid level; one byte per rising edge
- o_tx_data  out  DATA_W  byte to transmitter, valid while o_tx_write=1
- o_tx_write  out  1  write request to transmitter
- i_tx_busy  in  1  transmitter busy
- i_clr_ovf  in  1  clears o_overflow
- o_level  out  ADDR_W+1  FIFO occupancy, 0..2^ADDR_W
- o_empty / o_full  out  1  occupancy flags
- o_overflow  out  1  sticky, set on drop
- o_last_rx  out  DATA_W  last byte accepted, for LEDs
- o_rx_count / o_drop_count  out  CNT_W  statistics (see Configuration)

## Operation

- Registered copy of i_rx_ready gives edge detect. A push happens on the clock edge where i_rx_ready=1 and the previous sample was 0. A level held high pushes once.
- Push when not full: write i_rx_data at the write pointer, increment the pointer (wraps mod 2^ADDR_W), load o_last_rx.
- Push when full: byte is dropped, FIFO is unchanged, o_overflow is set, drop counter increments. o_last_rx still updates.
- o_overflow clears on i_clr_ovf. If a drop and i_clr_ovf occur on the same edge, set wins.
- TX state machine:
  - IDLE: if FIFO is non-empty and i_tx_busy=0, register the head byte to o_tx_data, set o_tx_write=1, go to REQ.
  - REQ: hold o_tx_write and o_tx_data until i_tx_busy=1 is sampled. On that edge, clear o_tx_write, pop the FIFO (read pointer +1), go to DRAIN.
  - DRAIN: wait for i_tx_busy=0, then go to IDLE.
- Simultaneous push and pop on one edge: level is unchanged and both pointers advance. A push into a full FIFO on the same edge as a pop is accepted, because "full" is evaluated after the pop.
- Byte order is preserved exactly; a byte is never sent twice or skipped.
- Reset sets pointers, level, flags, counters and o_tx_write to 0, o_tx_data and o_last_rx to 0, and the state to IDLE. Reset mid-REQ drops the request on the next edge and discards the FIFO contents. Because IDLE requires i_tx_busy=0, a transmission already in flight completes before any new write is issued.

## Timing

- i_rx_ready first sampled high at edge k → o_level and o_last_rx updated after edge k.
- If FIFO was empty, state is IDLE and i_tx_busy=0: o_tx_write=1 after edge k+1. Latency is 2 clocks from the i_rx_ready rise.
- i_tx_busy sampled high at edge m → o_tx_write=0 and o_level decremented after edge m.
- Back-to-back throughput is limited only by the transmitter: next o_tx_write one clock after i_tx_busy is sampled low.
- o_empty, o_full and o_level are registered and consistent with each other every cycle.

## Configuration

- FASTSERIAL_ECHO_STATS_EN defined:
  - o_rx_count increments on every detected rx edge, including drops.
  - o_drop_count increments on every drop.
  - Both are CNT_W wide, wrap at 2^CNT_W, and clear on reset.
- Undefined: no counter logic; o_rx_count and o_drop_count are tied to 0.

## Test plan

- Single byte: after reset, rx 0x41 with busy idle → o_tx_write=1 two clocks after the i_rx_ready rise with o_tx_data=0x41; pulse busy → o_tx_write falls, o_level=0.
- Burst/order: push 0x00..0x0F (ADDR_W=4) with busy held high → o_full=1, o_level=16; release busy → bytes emitted 0x00..0x0F in order.
- Overflow: 17 pushes while busy is high → 17th byte dropped, o_overflow=1, o_drop_count=1, o_rx_count=17; i_clr_ovf → o_overflow=0.
- Simultaneous push/pop at full: push on the same edge REQ sees busy → o_level stays 16 and the new byte is emitted last.
- Held ready: i_rx_ready high for 10 clocks → exactly one push.
- Reset mid-REQ: assert i_rst while o_tx_write=1 and busy=1 → o_tx_write=0, o_level=0 next edge; no write until busy is low and a new byte arrives.
